// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared definitions for the retirement trace unit: FSM encoding and entry layout.
// Entry layout, MSB first: {pc, wb_en, dest, data}. The trigger flag is not stored.
package pipeline_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trc_state_e;

  function automatic int rec_width(input int pc_w, input int reg_w, input int data_w);
    return pc_w + 1 + reg_w + data_w;
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x W register array, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 36,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Retirement trace unit: circular capture of write-back records, PC/force trigger with a
// post-trigger window, then oldest-first readout over a valid/ready port.
module pipeline_trace_buffer
  import pipeline_trace_buffer_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              force_trig_i,
  input  logic              trig_en_i,
  input  logic [PC_W-1:0]   trig_pc_i,
  input  logic [CNT_W-1:0]  post_cnt_i,
  input  logic              cap_valid_i,
  input  logic [PC_W-1:0]   cap_pc_i,
  input  logic              cap_wb_en_i,
  input  logic [REG_W-1:0]  cap_dest_i,
  input  logic [DATA_W-1:0] cap_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [PC_W-1:0]   rd_pc_o,
  output logic              rd_wb_en_o,
  output logic [REG_W-1:0]  rd_dest_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_trig_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = rec_width(PC_W, REG_W, DATA_W);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_MAX = CNT_W'(DEPTH - 1);

  trc_state_e       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_q, trig_d;
  logic [CNT_W-1:0] count_q, count_d, post_q, post_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_en, trig_cond, arm_go, xfer, last_xfer, enter_done;
  logic [RW-1:0]    wr_rec, rd_rec;

  assign trig_cond = (cap_valid_i & trig_en_i & (cap_pc_i == trig_pc_i)) | force_trig_i;
  assign arm_go    = (state_q == ST_IDLE) & arm_i & ~abort_i;
  assign xfer      = (state_q == ST_DONE) & rd_valid_q & rd_ready_i;
  assign last_xfer = xfer & (count_q == CNT_W'(1));

  // FSM: next state and write strobe
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE:  if (arm_i) state_d = ST_ARMED;
      ST_ARMED: begin
        wr_en = cap_valid_i;
        if (trig_cond) state_d = (post_q == '0) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        wr_en = cap_valid_i;
        if (cap_valid_i && post_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE:  if (last_xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
    end
  end

  assign enter_done = (state_d == ST_DONE) & (state_q != ST_DONE);

  // Datapath next values
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    trig_d     = trig_q;
    count_d    = count_q;
    post_d     = post_q;
    rd_valid_d = rd_valid_q;
    if (abort_i) begin
      count_d    = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (arm_go) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        post_d   = (post_cnt_i > POST_MAX) ? POST_MAX : post_cnt_i;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q != FULL) count_d = count_q + CNT_W'(1);
      end
      if (state_q == ST_POST && wr_en) post_d = post_q - CNT_W'(1);
      // A force trigger without a record marks the last entry already written.
      if (state_q == ST_ARMED && trig_cond)
        trig_d = cap_valid_i ? wr_ptr_q : wr_ptr_q - AW'(1);
      if (xfer) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q - CNT_W'(1);
        if (last_xfer) rd_valid_d = 1'b0;
      end
      // Oldest entry sits count positions behind the write pointer (count==DEPTH wraps to 0).
      if (enter_done) begin
        rd_ptr_d   = wr_ptr_d - count_d[AW-1:0];
        rd_valid_d = (count_d != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      trig_q     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      trig_q     <= trig_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign wr_rec = {cap_pc_i, cap_wb_en_i, cap_dest_i, cap_data_i};

  trace_ram #(.DEPTH(DEPTH), .W(RW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_rec),
    .raddr (rd_ptr_q),
    .rdata (rd_rec)
  );

  assign {rd_pc_o, rd_wb_en_o, rd_dest_o, rd_data_o} = rd_rec;
  assign rd_trig_o  = (rd_ptr_q == trig_q);
  assign rd_valid_o = rd_valid_q;
  assign state_o    = state_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench: two trace units (DEPTH 64 and 8) on shared stimulus, each checked every cycle
// against a history-list model of what the capture window and readout should hold.
module tb_pipeline_trace_buffer;

  logic        clk, rst;
  logic        arm, abort, force_trig, trig_en, cv, wb, rd_ready;
  logic [15:0] trig_pc, pc, data;
  logic [2:0]  dest;
  logic [7:0]  post;

  logic        rv64, rwb64, rt64, rv8, rwb8, rt8;
  logic [15:0] rp64, rdat64, rp8, rdat8;
  logic [2:0]  rdst64, rdst8;
  logic [1:0]  st64, st8;
  logic [6:0]  cnt64;
  logic [3:0]  cnt8;

  pipeline_trace_buffer #(.DEPTH(64)) u_d64 (
    .clk(clk), .rst(rst), .arm_i(arm), .abort_i(abort), .force_trig_i(force_trig),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc), .post_cnt_i(post[6:0]),
    .cap_valid_i(cv), .cap_pc_i(pc), .cap_wb_en_i(wb), .cap_dest_i(dest), .cap_data_i(data),
    .rd_valid_o(rv64), .rd_ready_i(rd_ready), .rd_pc_o(rp64), .rd_wb_en_o(rwb64),
    .rd_dest_o(rdst64), .rd_data_o(rdat64), .rd_trig_o(rt64), .state_o(st64), .count_o(cnt64)
  );

  pipeline_trace_buffer #(.DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .arm_i(arm), .abort_i(abort), .force_trig_i(force_trig),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc), .post_cnt_i(post[3:0]),
    .cap_valid_i(cv), .cap_pc_i(pc), .cap_wb_en_i(wb), .cap_dest_i(dest), .cap_data_i(data),
    .rd_valid_o(rv8), .rd_ready_i(rd_ready), .rd_pc_o(rp8), .rd_wb_en_o(rwb8),
    .rd_dest_o(rdst8), .rd_data_o(rdat8), .rd_trig_o(rt8), .state_o(st8), .count_o(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, nx64 = 0;

  // Model: every record captured since arm is kept in order; the buffer holds the
  // newest min(ncap, depth) of them and readout walks that window from its start.
  int          md[2] = '{64, 8};
  int          m_st[2], m_ncap[2], m_trig[2], m_post[2], m_nread[2];
  logic [35:0] hist[2][4096];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int held(input int k);
    return (m_ncap[k] < md[k]) ? m_ncap[k] : md[k];
  endfunction

  function automatic int mcount(input int k);
    case (m_st[k])
      0:       return 0;
      3:       return held(k) - m_nread[k];
      default: return held(k);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_ncap[k] = 0; m_trig[k] = -1; m_post[k] = 0; m_nread[k] = 0;
    end
  endtask

  task automatic store(input int k);
    if (m_ncap[k] < 4096) hist[k][m_ncap[k]] = {pc, wb, dest, data};
    m_ncap[k]++;
  endtask

  task automatic model_step(input int k);
    int d, p, c;
    bit trg;
    d = md[k];
    c = mcount(k);
    if (abort) begin
      m_st[k] = 0;
      return;
    end
    case (m_st[k])
      0: if (arm) begin
        m_st[k] = 1; m_ncap[k] = 0; m_nread[k] = 0; m_trig[k] = -1;
        p = int'(post) & (2 * d - 1);
        m_post[k] = (p > d - 1) ? d - 1 : p;
      end
      1: begin
        trg = (cv && trig_en && pc == trig_pc) || force_trig;
        if (cv) store(k);
        if (trg) begin
          m_trig[k] = m_ncap[k] - 1;
          m_st[k] = (m_post[k] == 0) ? 3 : 2;
        end
      end
      2: if (cv) begin
        store(k);
        m_post[k]--;
        if (m_post[k] == 0) m_st[k] = 3;
      end
      default: if (c > 0 && rd_ready) begin
        m_nread[k]++;
        if (c == 1) m_st[k] = 0;
      end
    endcase
  endtask

  task automatic check(input int k);
    logic [1:0]  st;
    logic [35:0] rec;
    logic        v, tr;
    int          cnt, c, idx;
    string       nm;
    nm = $sformatf("d%0d", md[k]);
    if (k == 0) begin st = st64; rec = {rp64, rwb64, rdst64, rdat64}; v = rv64; tr = rt64; cnt = int'(cnt64); end
    else        begin st = st8;  rec = {rp8, rwb8, rdst8, rdat8};     v = rv8;  tr = rt8;  cnt = int'(cnt8);  end
    c = mcount(k);
    chk({nm, "_state"}, 64'(st), 64'(m_st[k]));
    chk({nm, "_count"}, 64'(cnt), 64'(c));
    chk({nm, "_rd_valid"}, 64'(v), 64'(m_st[k] == 3 && c > 0));
    if (m_st[k] == 3 && c > 0) begin
      idx = m_ncap[k] - held(k) + m_nread[k];
      chk({nm, "_rd_rec"}, 64'(rec), 64'(hist[k][idx]));
      chk({nm, "_rd_trig"}, 64'(tr), 64'(idx == m_trig[k]));
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) model_step(k);
    if (rv64 && rd_ready) nx64++;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check(k);
  endtask

  task automatic clr();
    arm = 0; abort = 0; force_trig = 0; cv = 0; rd_ready = 0;
    pc = '0; wb = 0; dest = '0; data = '0;
  endtask

  task automatic do_arm(input int p, input int tpc, input bit en);
    clr();
    arm = 1; post = 8'(p); trig_pc = 16'(tpc); trig_en = en;
    tick();
    arm = 0;
  endtask

  task automatic cap(input int cpc);
    cv = 1; pc = 16'(cpc); wb = 1'($urandom); dest = 3'($urandom); data = 16'($urandom);
    tick();
    cv = 0;
  endtask

  // mode 0: always ready; mode 1: stall 4 cycles, then ready every other cycle
  task automatic drain(input int mode);
    int t;
    t = 0;
    clr();
    nx64 = 0;
    while ((st64 != 2'd0 || st8 != 2'd0) && t < 300) begin
      rd_ready = (mode == 0) ? 1'b1 : ((t < 4) ? 1'b0 : 1'(t % 2));
      tick();
      t++;
    end
    chk("drain_done", 64'(st64 == 2'd0 && st8 == 2'd0), 64'd1);
    clr();
  endtask

  initial begin
    rst = 0; trig_en = 0; trig_pc = '0; post = '0;
    clr();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) check(k);

    // Basic window: trigger at 0x10, three more records, DONE after 0x16
    do_arm(3, 16'h0010, 1);
    for (int p = 0; p <= 32; p += 2) cap(p);
    chk("basic_cnt64", 64'(cnt64), 64'd12);
    drain(0);
    chk("basic_nread", 64'(nx64), 64'd12);

    // Wrap in the 8-deep unit: PCs 10..17 remain
    do_arm(2, 15, 1);
    for (int p = 0; p < 20; p++) cap(p);
    chk("wrap_cnt8", 64'(cnt8), 64'd8);
    drain(0);

    // Post count 0 with a force trigger on an idle cycle
    do_arm(0, 0, 0);
    for (int p = 1; p <= 5; p++) cap(p);
    force_trig = 1;
    tick();
    force_trig = 0;
    chk("force_state", 64'(st64), 64'd3);
    drain(0);
    chk("force_nread", 64'(nx64), 64'd5);

    // Backpressure on a 5-entry readout
    do_arm(1, 3, 1);
    for (int p = 0; p < 6; p++) cap(p);
    drain(1);
    chk("bp_nread", 64'(nx64), 64'd5);

    // Abort after two of six reads
    do_arm(1, 4, 1);
    for (int p = 0; p < 6; p++) cap(p);
    rd_ready = 1;
    tick();
    tick();
    rd_ready = 0;
    abort = 1;
    tick();
    abort = 0;
    chk("abort_cnt64", 64'(cnt64), 64'd0);

    // Ignored arm in ARMED, ignored triggers in POST
    do_arm(3, 7, 1);
    cap(6);
    arm = 1; post = 0;
    tick();
    arm = 0;
    cap(7);
    force_trig = 1;
    tick();
    force_trig = 0;
    cap(7);
    chk("post_hold_state", 64'(st64), 64'd2);
    abort = 1;
    tick();
    abort = 0;

    // Asynchronous reset in POST with 20 entries held
    do_arm(30, 0, 1);
    for (int p = 0; p < 20; p++) cap(p);
    chk("rst_pre_cnt64", 64'(cnt64), 64'd20);
    rst = 0;
    #1;
    model_reset();
    chk("rst_state", 64'(st64), 64'd0);
    chk("rst_cnt", 64'(cnt64), 64'd0);
    chk("rst_rv", 64'(rv64 | rv8), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    do_arm(1, 3, 1);
    for (int p = 0; p < 5; p++) cap(p);
    drain(0);
    chk("rearm_nread", 64'(nx64), 64'd5);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      abort      = ($urandom % 100) < 2;
      arm        = ($urandom % 100) < 5;
      force_trig = ($urandom % 100) < 3;
      cv         = ($urandom % 100) < 70;
      pc         = 16'($urandom % 32);
      wb         = 1'($urandom);
      dest       = 3'($urandom);
      data       = 16'($urandom);
      rd_ready   = ($urandom % 100) < 60;
      post       = 8'($urandom % 12);
      if (($urandom % 100) < 5) begin
        trig_pc = 16'($urandom % 32);
        trig_en = 1'($urandom);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
